// File: rtl/part_dpram_p_pkg.sv
`default_nettype none
// ============================================================================
// Module   : part_dpram_p_pkg
// Brief    : Shared state encodings and latency helper for the dual-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
package part_dpram_p_pkg;

    typedef enum logic [0:0] {
        PDP_INIT = 1'b0,
        PDP_RUN  = 1'b1
    } pdp_state_t;

    // Read latency seen by callers for a given OUT_REG setting.
    function automatic int ram_lat(input int out_reg);
        return 1 + out_reg;
    endfunction

endpackage : part_dpram_p_pkg
`default_nettype wire

// File: rtl/part_dpram_clr.sv
`default_nettype none
// ============================================================================
// Module   : part_dpram_clr
// Brief    : Post-reset sequencer; optionally zeroes every word, then asserts ready.
// Revision : 1.0 - initial release
// ============================================================================
module part_dpram_clr
    import part_dpram_p_pkg::*;
#(
    parameter int AW         = 10,
    parameter int INIT_CLEAR = 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr,
    output logic          o_ready
);

    localparam logic [AW-1:0] c_LAST_ADDR = '1;

    pdp_state_t    r_state;
    pdp_state_t    w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_nxt;
    logic          w_clr_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PDP_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_clr_we    = 1'b0;
        case (r_state)
            PDP_INIT: begin
                if (INIT_CLEAR != 0) begin
                    w_clr_we  = 1'b1;
                    w_ptr_nxt = r_ptr + 1'b1;
                    if (r_ptr == c_LAST_ADDR) begin
                        w_state_nxt = PDP_RUN;
                    end
                end else begin
                    w_state_nxt = PDP_RUN;
                end
            end
            PDP_RUN: begin
                w_state_nxt = PDP_RUN;
            end
            default: begin
                w_state_nxt = PDP_INIT;
            end
        endcase
    end

    // Reset edges must never touch the array, so the clear strobe is masked.
    assign o_clr_we   = w_clr_we & ~rst;
    assign o_clr_addr = r_ptr;
    assign o_ready    = (r_state == PDP_RUN);

endmodule : part_dpram_clr
`default_nettype wire

// File: rtl/part_dpram_p.sv
`default_nettype none
// ============================================================================
// Module   : part_dpram_p
// Brief    : Parametrised single-clock true dual-port RAM with collision flag.
// Revision : 1.0 - initial release
// ============================================================================
module part_dpram_p
    import part_dpram_p_pkg::*;
#(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int OUT_REG    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic          ready,
    input  logic [AW-1:0] address_a,
    input  logic [DW-1:0] data_a,
    input  logic          wren_a,
    input  logic          rden_a,
    output logic [DW-1:0] q_a,
    input  logic [AW-1:0] address_b,
    input  logic [DW-1:0] data_b,
    input  logic          wren_b,
    input  logic          rden_b,
    output logic [DW-1:0] q_b,
    output logic          collide
);

    localparam int c_DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [c_DEPTH];

    logic          w_ready;
    logic          w_clr_we;
    logic [AW-1:0] w_clr_addr;
    logic          w_we_a;
    logic          w_we_b;
    logic          w_rd_a;
    logic          w_rd_b;
    logic          w_same_addr;
    logic          w_b_dropped;
    logic          r_collide;
    logic [DW-1:0] r_q_a;
    logic [DW-1:0] r_q_b;

    part_dpram_clr #(
        .AW         (AW),
        .INIT_CLEAR (INIT_CLEAR)
    ) u_clr (
        .clk        (clk),
        .rst        (reset),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_ready    (w_ready)
    );

    assign w_we_a      = wren_a & w_ready;
    assign w_we_b      = wren_b & w_ready;
    assign w_rd_a      = rden_a & w_ready;
    assign w_rd_b      = rden_b & w_ready;
    assign w_same_addr = (address_a == address_b);
    assign w_b_dropped = w_we_a & w_we_b & w_same_addr;

    // Port A wins a same-address write; B is dropped.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else begin
            if (w_we_a) begin
                r_mem[address_a] <= data_a;
            end
            if (w_we_b && !w_b_dropped) begin
                r_mem[address_b] <= data_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_collide <= 1'b0;
        end else begin
            r_collide <= w_b_dropped;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] r_s1_a;
            logic [DW-1:0] r_s1_b;
            logic          r_s1_va;
            logic          r_s1_vb;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_s1_a  <= '0;
                    r_s1_b  <= '0;
                    r_s1_va <= 1'b0;
                    r_s1_vb <= 1'b0;
                    r_q_a   <= '0;
                    r_q_b   <= '0;
                end else begin
                    r_s1_va <= w_rd_a;
                    r_s1_vb <= w_rd_b;
                    if (w_rd_a) begin
                        r_s1_a <= r_mem[address_a];
                    end
                    if (w_rd_b) begin
                        r_s1_b <= r_mem[address_b];
                    end
                    if (r_s1_va) begin
                        r_q_a <= r_s1_a;
                    end
                    if (r_s1_vb) begin
                        r_q_b <= r_s1_b;
                    end
                end
            end
        end else begin : g_no_out_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_q_a <= '0;
                    r_q_b <= '0;
                end else begin
                    if (w_rd_a) begin
                        r_q_a <= r_mem[address_a];
                    end
                    if (w_rd_b) begin
                        r_q_b <= r_mem[address_b];
                    end
                end
            end
        end
    endgenerate

    assign ready   = w_ready;
    assign q_a     = r_q_a;
    assign q_b     = r_q_b;
    assign collide = r_collide;

endmodule : part_dpram_p
`default_nettype wire

// File: tb/tb_part_dpram_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_part_dpram_p
// Brief    : Scoreboard bench driving one stimulus into OUT_REG=0 and OUT_REG=1 RAMs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_part_dpram_p;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] address_a, address_b;
    logic [DW-1:0] data_a, data_b;
    logic          wren_a, wren_b, rden_a, rden_b;

    logic          ready0, ready1, col0, col1;
    logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    part_dpram_p #(.AW(AW), .DW(DW), .OUT_REG(0), .INIT_CLEAR(1)) u_dut0 (
        .clk(clk), .reset(reset), .ready(ready0),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a), .q_a(q_a0),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .rden_b(rden_b), .q_b(q_b0),
        .collide(col0)
    );

    part_dpram_p #(.AW(AW), .DW(DW), .OUT_REG(1), .INIT_CLEAR(1)) u_dut1 (
        .clk(clk), .reset(reset), .ready(ready1),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a), .q_a(q_a1),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .rden_b(rden_b), .q_b(q_b1),
        .collide(col1)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One-edge write on either/both ports; returns at the negedge after the edge.
    task automatic do_write(input bit wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                            input bit wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
        @(negedge clk);
        wren_a = wa; address_a = aa; data_a = da;
        wren_b = wb; address_b = ab; data_b = db;
        @(negedge clk);
        wren_a = 1'b0; wren_b = 1'b0;
        if (wb && !(wa && aa == ab)) model[ab] = db;
        if (wa) model[aa] = da;
    endtask

    // One-edge read; d0 is sampled after latency 1, d1 after latency 2.
    task automatic do_read(input bit port, input logic [AW-1:0] addr,
                           output logic [DW-1:0] d0, output logic [DW-1:0] d1);
        @(negedge clk);
        if (port) begin address_b = addr; rden_b = 1'b1; end
        else      begin address_a = addr; rden_a = 1'b1; end
        exp_q.push_back(model[addr]);
        @(negedge clk);
        rden_a = 1'b0; rden_b = 1'b0;
        d0 = port ? q_b0 : q_a0;
        @(negedge clk);
        d1 = port ? q_b1 : q_a1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wren_a = 0; wren_b = 0; rden_a = 0; rden_b = 0;
        address_a = '0; address_b = '0; data_a = '0; data_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ready0, ready1} !== 2'b00) begin
            n_errors++; $display("FAIL reset_ready: got %b%b want 00", ready0, ready1);
        end
        n_checks++;
        if ({q_a0, q_b0, q_a1, q_b1} !== '0) begin
            n_errors++; $display("FAIL reset_q: got %h %h %h %h want 0", q_a0, q_b0, q_a1, q_b1);
        end
        n_checks++;
        if ({col0, col1} !== 2'b00) begin
            n_errors++; $display("FAIL reset_collide: got %b%b want 00", col0, col1);
        end
    endtask

    task automatic test_init_clear();
        logic [DW-1:0] d0, d1, e;
        // Writes/reads attempted while clearing must be ignored.
        reset = 1'b0;
        wren_a = 1'b1; address_a = 4'd3; data_a = 32'hFFFF_FFFF;
        wren_b = 1'b1; address_b = 4'd12; data_b = 32'h1234_5678;
        rden_a = 1'b1; rden_b = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            if (i == DEPTH - 1) begin
                wren_a = 0; wren_b = 0; rden_a = 0; rden_b = 0;
            end
            n_checks++;
            if (ready0 !== (i == DEPTH) || ready1 !== (i == DEPTH)) begin
                n_errors++;
                $display("FAIL init_ready edge %0d: got %b%b want %b", i, ready0, ready1, i == DEPTH);
            end
            if (i < DEPTH) begin
                n_checks++;
                if ({q_a0, q_b0, q_a1, q_b1} !== '0) begin
                    n_errors++; $display("FAIL init_q_hold edge %0d: got %h %h want 0", i, q_a0, q_a1);
                end
            end
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            do_read(i[0], i[AW-1:0], d0, d1);
            e = exp_q.pop_front();
            n_checks++;
            if (d0 !== e || d1 !== e) begin
                n_errors++; $display("FAIL init_zero addr %0d: got %h/%h want %h", i, d0, d1, e);
            end
        end
    endtask

    task automatic test_parallel_write();
        logic [DW-1:0] d0, d1, e;
        do_write(1, 4'd3, 32'o1234, 1, 4'd5, 32'o7777);
        n_checks++;
        if ({col0, col1} !== 2'b00) begin
            n_errors++; $display("FAIL par_collide: got %b%b want 00", col0, col1);
        end
        do_read(0, 4'd3, d0, d1);
        e = exp_q.pop_front();
        n_checks++;
        if (d0 !== e || d1 !== e || e !== 32'o1234) begin
            n_errors++; $display("FAIL par_ram3: got %h/%h want %h", d0, d1, 32'o1234);
        end
        do_read(1, 4'd5, d0, d1);
        e = exp_q.pop_front();
        n_checks++;
        if (d0 !== e || d1 !== e) begin
            n_errors++; $display("FAIL par_ram5: got %h/%h want %h", d0, d1, e);
        end
    endtask

    task automatic test_collision();
        logic [DW-1:0] d0, d1, e;
        do_write(1, 4'd7, 32'hAAAA_0001, 1, 4'd7, 32'h5555_FFFF);
        n_checks++;
        if ({col0, col1} !== 2'b11) begin
            n_errors++; $display("FAIL col_pulse: got %b%b want 11", col0, col1);
        end
        @(negedge clk);
        n_checks++;
        if ({col0, col1} !== 2'b00) begin
            n_errors++; $display("FAIL col_one_cycle: got %b%b want 00", col0, col1);
        end
        do_read(1, 4'd7, d0, d1);
        e = exp_q.pop_front();
        n_checks++;
        if (d0 !== e || d1 !== e || e !== 32'hAAAA_0001) begin
            n_errors++; $display("FAIL col_ram7: got %h/%h want %h", d0, d1, 32'hAAAA_0001);
        end
    endtask

    task automatic test_read_during_write();
        logic [DW-1:0] d0, d1, e;
        do_write(1, 4'd2, 32'h11, 0, 4'd0, 32'h0);
        // Mixed-port: A writes, B reads the same word on one edge.
        @(negedge clk);
        wren_a = 1; address_a = 4'd2; data_a = 32'h22;
        rden_b = 1; address_b = 4'd2;
        exp_q.push_back(model[2]);
        exp_q.push_back(model[2]);
        @(negedge clk);
        wren_a = 0; rden_b = 0;
        model[2] = 32'h22;
        e = exp_q.pop_front();
        n_checks++;
        if (q_b0 !== e) begin
            n_errors++; $display("FAIL rdw_mixed_lat1: got %h want %h", q_b0, e);
        end
        @(negedge clk);
        e = exp_q.pop_front();
        n_checks++;
        if (q_b1 !== e) begin
            n_errors++; $display("FAIL rdw_mixed_lat2: got %h want %h", q_b1, e);
        end
        do_read(1, 4'd2, d0, d1);
        e = exp_q.pop_front();
        n_checks++;
        if (d0 !== e || d1 !== e || e !== 32'h22) begin
            n_errors++; $display("FAIL rdw_repeat: got %h/%h want 22", d0, d1);
        end
        // Same-port: A writes and reads word 4 on one edge.
        do_write(1, 4'd4, 32'h44, 0, 4'd0, 32'h0);
        @(negedge clk);
        wren_a = 1; rden_a = 1; address_a = 4'd4; data_a = 32'h55;
        exp_q.push_back(model[4]);
        @(negedge clk);
        wren_a = 0; rden_a = 0;
        model[4] = 32'h55;
        e = exp_q.pop_front();
        n_checks++;
        if (q_a0 !== e) begin
            n_errors++; $display("FAIL rdw_same: got %h want %h", q_a0, e);
        end
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic [DW-1:0] e;
        do_write(0, 4'd0, 32'h0, 1, 4'd9, 32'h3C);
        @(negedge clk);
        rden_a = 1; address_a = 4'd9;
        exp_q.push_back(model[9]);
        @(negedge clk);
        rden_a = 0;
        e = exp_q.pop_front();
        n_checks++;
        if (q_a0 !== e) begin
            n_errors++; $display("FAIL lat_out0: got %h want %h", q_a0, e);
        end
        n_checks++;
        if (q_a1 === e) begin
            n_errors++; $display("FAIL lat_out1_early: got %h want not %h", q_a1, e);
        end
        @(negedge clk);
        n_checks++;
        if (q_a1 !== e) begin
            n_errors++; $display("FAIL lat_out1: got %h want %h", q_a1, e);
        end
        // With rden low, outputs hold even when the address moves.
        address_a = 4'd3;
        repeat (2) @(negedge clk);
        n_checks++;
        if (q_a0 !== e || q_a1 !== e) begin
            n_errors++; $display("FAIL lat_hold: got %h/%h want %h", q_a0, q_a1, e);
        end
    endtask

    task automatic test_reset_mid_init();
        logic [DW-1:0] d0, d1, e;
        do_write(1, 4'd2, 32'hBEEF, 1, 4'd12, 32'hDEAD);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        repeat (8) @(negedge clk);
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            @(negedge clk);
            n_checks++;
            if (ready0 !== (i == DEPTH) || ready1 !== (i == DEPTH)) begin
                n_errors++;
                $display("FAIL mid_ready edge %0d: got %b%b want %b", i, ready0, ready1, i == DEPTH);
            end
        end
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        do_read(0, 4'd2, d0, d1);
        e = exp_q.pop_front();
        n_checks++;
        if (d0 !== e || d1 !== e) begin
            n_errors++; $display("FAIL mid_ram2: got %h/%h want %h", d0, d1, e);
        end
        do_read(1, 4'd12, d0, d1);
        e = exp_q.pop_front();
        n_checks++;
        if (d0 !== e || d1 !== e) begin
            n_errors++; $display("FAIL mid_ram12: got %h/%h want %h", d0, d1, e);
        end
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_parallel_write();
        test_collision();
        test_read_during_write();
        test_latency();
        test_reset_mid_init();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_part_dpram_p
`default_nettype wire

// File: doc/part_dpram_p.md
Name: part_dpram_p

Overview:
- Parametrised single-clock true dual-port synchronous RAM. Successor to the fixed 1kx32 PDL RAM; used for PDL, SPC and similar scratch memories in the CADR core.
- Adds generic width/depth, true simultaneous two-port writes, and defined collision arbitration with a collision flag.
- Adds an optional output pipeline register and a post-reset clearing sequencer with a ready handshake.

Parameters:
- AW, 10, address width; depth DEPTH = 2**AW words.
- DW, 32, data word width.
- OUT_REG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2.
- INIT_CLEAR, 1, 1 = zero every word after reset before asserting ready; 0 = ready the cycle after reset deasserts.

Ports:
- clk, in, 1, single clock; all logic on posedge.
- reset, in, 1, synchronous, active-high.
- ready, out, 1, high when the RAM accepts requests.
- address_a, in, AW, port A address.
- data_a, in, DW, port A write data.
- wren_a, in, 1, port A write enable.
- rden_a, in, 1, port A read enable.
- q_a, out, DW, port A read data.
- address_b, in, AW, port B address.
- data_b, in, DW, port B write data.
- wren_b, in, 1, port B write enable.
- rden_b, in, 1, port B read enable.
- q_b, out, DW, port B read data.
- collide, out, 1, one-cycle pulse: both ports wrote the same address.

Behaviour:
- Reset state (any edge with reset=1):
  - state=INIT, clear pointer=0.
  - ready=0, q_a=q_b=0, collide=0.
  - All pipeline registers are 0.
  - RAM contents are untouched by reset itself.
- FSM states:
  - INIT, INIT_CLEAR=1: each edge with reset=0 writes 0 to ram[ptr] and increments ptr. The edge that writes DEPTH-1 moves to RUN and sets ready=1. ready is first high DEPTH edges after reset deasserts.
  - INIT, INIT_CLEAR=0: the first edge with reset=0 moves to RUN with ready=1.
  - RUN: stays in RUN until reset.
  - Reset during INIT or RUN returns to INIT with ptr=0, so clearing restarts from address 0.
- Gating: while ready=0, all wren/rden inputs are ignored, and q_a/q_b hold 0.
- Writes in RUN:
  - wren_a writes data_a to ram[address_a]; wren_b writes data_b to ram[address_b]. Both happen on the same edge when the addresses differ.
  - Same address, both wren: port A wins, port B's write is dropped, and collide=1 on the following cycle only.
- Reads in RUN:
  - rden_x at edge N loads q_x with ram[address_x] at edge N (OUT_REG=0) or edge N+1 (OUT_REG=1).
  - With rden_x=0, q_x holds its last value. With OUT_REG=1, the output stage loads only when the stage-1 valid bit is set.
- Read-during-write, same port and mixed ports: reads return OLD data, i.e. the contents before the edge.
- Widths: addresses are used as-is and DEPTH is a power of two, so no out-of-range case exists. ptr is AW bits wide and its wrap is never reached because INIT exits at DEPTH-1.
- Inputs are never X-propagated into state: reset dominates all other inputs.

Decomposition:
- Shared package/defines.vh: RAM state encodings (PDP_INIT, PDP_RUN) and a common RAM_LAT macro computing 1+OUT_REG for callers.
- Sub-module part_dpram_clr: the INIT sequencer. It holds the counter and FSM and exports clr_we, clr_addr and ready. The top keeps the storage array, arbitration and output pipeline.

Test Plan:
- Reset, AW=4, INIT_CLEAR=1: deassert reset -> ready=0 for 16 edges, then 1. Reads of all addresses then return 0. Writes attempted during INIT have no effect (verified by reading back 0).
- Parallel write: wren_a addr 3 data 0o1234, wren_b addr 5 data 0o7777 on one edge -> later reads give ram[3]=0o1234 and ram[5]=0o7777, with collide=0.
- Collision: both ports write addr 7, A=0xAAAA0001, B=0x5555FFFF -> collide pulses high for exactly one cycle, and ram[7]=0xAAAA0001.
- Read-during-write: ram[2]=0x11. A writes 0x22 to addr 2 while B reads addr 2 on the same edge -> q_b=0x11. A repeat read gives 0x22.
- Latency, OUT_REG=1: rden_a at edge N on addr 9 (holding 0x3C) -> q_a=0x3C at edge N+1 and not at edge N.
- Reset mid-INIT at ptr=8, then release -> ptr restarts at 0, and ready rises 16 edges after release. Words written before the earlier reset are zero afterward.
